data_controller: RTL and testbench

// Responder end of the main-controller <-> data-controller handshake in the WinoCNN datapath.
// On data_prepare_i it requests an input-channel load into the input buffer and raises data_ready_o when the load is done.
// On the data_start_i rising edge it scans Winograd input tiles over the feature map and hands out one tile origin per handshake to the PE array.

---
 rtl/wino_pkg.sv | 25 ++
 rtl/tile_scan_counter.sv | 94 +++++++++
 rtl/data_controller.sv | 146 ++++++++++++++
 tb/tb_data_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wino_pkg.sv
// Shared types and Winograd tile geometry for the data-controller datapath.
// F(2,3) uses 4x4 input tiles stepping by 2; F(4,3) uses 6x6 tiles stepping by 4.
package wino_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StReady,
        StStream,
        StDone
    } state_e;

    typedef enum logic {
        SizeF23 = 1'b0,
        SizeF43 = 1'b1
    } size_type_e;

    localparam int unsigned TileF23  = 4;
    localparam int unsigned StepF23  = 2;
    localparam int unsigned ShiftF23 = 1;
    localparam int unsigned TileF43  = 6;
    localparam int unsigned StepF43  = 4;
    localparam int unsigned ShiftF43 = 2;

endpackage

// File: rtl/tile_scan_counter.sv
// 2-D tile origin stepper: walks origins row-major over the feature map and
// flags the final tile and tiles that overhang the image edge.
module tile_scan_counter
    import wino_pkg::*;
#(
    parameter int unsigned DIM_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             size_type_i,
    input  logic [DIM_W-1:0] width_i,
    input  logic [DIM_W-1:0] height_i,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [DIM_W-1:0] x_o,
    output logic [DIM_W-1:0] y_o,
    output logic             last_o,
    output logic             partial_o,
    output logic             empty_o
);

    logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
    logic [DIM_W-1:0] xi_q, xi_d, yi_q, yi_d;
    logic [DIM_W-1:0] step;
    logic [DIM_W:0]   tile_w, nx, ny;
    logic             last_col, last_row;

    // ceil((dim-2)/STEP) via add-and-shift; the extra bit keeps the sum from wrapping.
    function automatic logic [DIM_W:0] tiles_per_axis(input logic [DIM_W-1:0] dim,
                                                      input logic f43);
        logic [DIM_W:0] num;
        num = {1'b0, dim} - (DIM_W+1)'(2);
        if (dim < DIM_W'(3)) begin
            return '0;
        end
        if (f43) begin
            return (num + (DIM_W+1)'(StepF43 - 1)) >> ShiftF43;
        end
        return (num + (DIM_W+1)'(StepF23 - 1)) >> ShiftF23;
    endfunction

    always_comb begin
        step   = (size_type_i == SizeF43) ? DIM_W'(StepF43) : DIM_W'(StepF23);
        tile_w = (size_type_i == SizeF43) ? (DIM_W+1)'(TileF43) : (DIM_W+1)'(TileF23);
        nx     = tiles_per_axis(width_i, size_type_i);
        ny     = tiles_per_axis(height_i, size_type_i);

        last_col = ({1'b0, xi_q} + (DIM_W+1)'(1)) == nx;
        last_row = ({1'b0, yi_q} + (DIM_W+1)'(1)) == ny;

        x_d  = x_q;
        y_d  = y_q;
        xi_d = xi_q;
        yi_d = yi_q;
        if (clear_i) begin
            x_d  = '0;
            y_d  = '0;
            xi_d = '0;
            yi_d = '0;
        end else if (advance_i) begin
            if (last_col) begin
                x_d  = '0;
                xi_d = '0;
                y_d  = y_q + step;
                yi_d = yi_q + DIM_W'(1);
            end else begin
                x_d  = x_q + step;
                xi_d = xi_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q  <= '0;
            y_q  <= '0;
            xi_q <= '0;
            yi_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            xi_q <= xi_d;
            yi_q <= yi_d;
        end
    end

    assign x_o       = x_q;
    assign y_o       = y_q;
    assign last_o    = last_col & last_row;
    assign partial_o = (({1'b0, x_q} + tile_w) > {1'b0, width_i}) ||
                       (({1'b0, y_q} + tile_w) > {1'b0, height_i});
    assign empty_o   = (nx == '0) || (ny == '0);

endmodule

// File: rtl/data_controller.sv
// Responder side of the main-controller handshake: loads one input channel,
// then streams Winograd tile origins to the PE array on a start edge.
module data_controller
    import wino_pkg::*;
#(
    parameter int unsigned ID_W  = 4,
    parameter int unsigned DIM_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_wen_i,
    input  logic [DIM_W-1:0] total_width_i,
    input  logic [DIM_W-1:0] total_height_i,
    input  logic             total_size_type_i,
    input  logic             data_prepare_i,
    input  logic             data_start_i,
    input  logic [ID_W-1:0]  data_id_i,
    output logic             data_ready_o,
    output logic             data_complete_o,
    output logic             load_req_o,
    output logic [ID_W-1:0]  load_id_o,
    input  logic             load_done_i,
    output logic             tile_valid_o,
    input  logic             tile_ready_i,
    output logic [DIM_W-1:0] tile_x_o,
    output logic [DIM_W-1:0] tile_y_o,
    output logic             tile_last_o,
    output logic             tile_partial_o
);

    state_e           state_q, state_d;
    logic             start_q, start_rise;
    logic [DIM_W-1:0] width_q, width_d, height_q, height_d;
    logic             size_type_q, size_type_d;
    logic [ID_W-1:0]  load_id_q, load_id_d;
    logic             load_req_q, load_req_d;
    logic             ready_q, ready_d;
    logic             complete_q, complete_d;
    logic             valid_q, valid_d;
    logic             scan_clear, scan_advance, accept;
    logic [DIM_W-1:0] scan_x, scan_y;
    logic             scan_last, scan_partial, scan_empty;

    assign start_rise = data_start_i & ~start_q;
    assign accept     = valid_q & tile_ready_i;

    always_comb begin
        state_d      = state_q;
        load_id_d    = load_id_q;
        width_d      = width_q;
        height_d     = height_q;
        size_type_d  = size_type_q;
        scan_clear   = 1'b0;
        scan_advance = 1'b0;

        if (cfg_wen_i && (state_q == StIdle || state_q == StDone)) begin
            width_d     = total_width_i;
            height_d    = total_height_i;
            size_type_d = total_size_type_i;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (data_prepare_i) begin
                    state_d   = StLoad;
                    load_id_d = data_id_i;
                end
            end
            StLoad: begin
                if (load_done_i) state_d = StReady;
            end
            StReady: begin
                if (start_rise) begin
                    scan_clear = 1'b1;
                    state_d    = scan_empty ? StDone : StStream;
                end
            end
            StStream: begin
                scan_advance = accept;
                if (accept && scan_last) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with it.
        load_req_d = (state_d == StLoad) && (state_q != StLoad);
        ready_d    = (state_d == StReady);
        valid_d    = (state_d == StStream);
        complete_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            start_q     <= 1'b0;
            width_q     <= '0;
            height_q    <= '0;
            size_type_q <= 1'b0;
            load_id_q   <= '0;
            load_req_q  <= 1'b0;
            ready_q     <= 1'b0;
            complete_q  <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= data_start_i;
            width_q     <= width_d;
            height_q    <= height_d;
            size_type_q <= size_type_d;
            load_id_q   <= load_id_d;
            load_req_q  <= load_req_d;
            ready_q     <= ready_d;
            complete_q  <= complete_d;
            valid_q     <= valid_d;
        end
    end

    tile_scan_counter #(
        .DIM_W(DIM_W)
    ) u_scan (
        .clk        (clk),
        .reset      (reset),
        .size_type_i(size_type_q),
        .width_i    (width_q),
        .height_i   (height_q),
        .clear_i    (scan_clear),
        .advance_i  (scan_advance),
        .x_o        (scan_x),
        .y_o        (scan_y),
        .last_o     (scan_last),
        .partial_o  (scan_partial),
        .empty_o    (scan_empty)
    );

    assign data_ready_o    = ready_q;
    assign data_complete_o = complete_q;
    assign load_req_o      = load_req_q;
    assign load_id_o       = load_id_q;
    assign tile_valid_o    = valid_q;
    // Tile fields read as zero whenever no tile is being offered.
    assign tile_x_o        = valid_q ? scan_x : '0;
    assign tile_y_o        = valid_q ? scan_y : '0;
    assign tile_last_o     = valid_q & scan_last;
    assign tile_partial_o  = valid_q & scan_partial;

endmodule

// File: tb/tb_data_controller.sv
// Scoreboard bench for data_controller: a tile-list model feeds an expected queue,
// and an independent monitor pops it on every accepted tile.
module tb_data_controller;

    localparam int ID_W  = 4;
    localparam int DIM_W = 9;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_wen_i = 1'b0;
    logic [DIM_W-1:0] total_width_i = '0;
    logic [DIM_W-1:0] total_height_i = '0;
    logic             total_size_type_i = 1'b0;
    logic             data_prepare_i = 1'b0;
    logic             data_start_i = 1'b0;
    logic [ID_W-1:0]  data_id_i = '0;
    logic             data_ready_o, data_complete_o, load_req_o;
    logic [ID_W-1:0]  load_id_o;
    logic             load_done_i = 1'b0;
    logic             tile_valid_o;
    logic             tile_ready_i = 1'b0;
    logic [DIM_W-1:0] tile_x_o, tile_y_o;
    logic             tile_last_o, tile_partial_o;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int stall_cnt = 0;

    data_controller #(
        .ID_W (ID_W),
        .DIM_W(DIM_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_wen_i        (cfg_wen_i),
        .total_width_i    (total_width_i),
        .total_height_i   (total_height_i),
        .total_size_type_i(total_size_type_i),
        .data_prepare_i   (data_prepare_i),
        .data_start_i     (data_start_i),
        .data_id_i        (data_id_i),
        .data_ready_o     (data_ready_o),
        .data_complete_o  (data_complete_o),
        .load_req_o       (load_req_o),
        .load_id_o        (load_id_o),
        .load_done_i      (load_done_i),
        .tile_valid_o     (tile_valid_o),
        .tile_ready_i     (tile_ready_i),
        .tile_x_o         (tile_x_o),
        .tile_y_o         (tile_y_o),
        .tile_last_o      (tile_last_o),
        .tile_partial_o   (tile_partial_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Tile list straight from the geometry: row-major origins at multiples of STEP.
    task automatic push_model(input int w, input int h, input int t, output int n);
        int step, tile, nx, ny, x, y, last, part;
        step = t ? 4 : 2;
        tile = t ? 6 : 4;
        nx = (w < 3) ? 0 : (w - 2 + step - 1) / step;
        ny = (h < 3) ? 0 : (h - 2 + step - 1) / step;
        for (int j = 0; j < ny; j++) begin
            for (int i = 0; i < nx; i++) begin
                x = i * step;
                y = j * step;
                last = (i == nx - 1 && j == ny - 1) ? 1 : 0;
                part = (x + tile > w || y + tile > h) ? 1 : 0;
                exp_q.push_back((x << 11) | (y << 2) | (last << 1) | part);
            end
        end
        n = nx * ny;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, tile_valid_o, 0);
        check({tag, "_ready"}, data_ready_o, 0);
        check({tag, "_complete"}, data_complete_o, 0);
        check({tag, "_load_req"}, load_req_o, 0);
        check({tag, "_load_id"}, load_id_o, 0);
        check({tag, "_tile"}, {tile_x_o, tile_y_o, tile_last_o, tile_partial_o}, 0);
    endtask

    task automatic configure(input int w, input int h, input int t);
        tick();
        cfg_wen_i = 1'b1;
        total_width_i = DIM_W'(w);
        total_height_i = DIM_W'(h);
        total_size_type_i = t[0];
        tick();
        cfg_wen_i = 1'b0;
    endtask

    task automatic load(input int id);
        tick();
        data_prepare_i = 1'b1;
        data_id_i = ID_W'(id);
        sample();
        check("load_req_pulse", load_req_o, 1);
        check("load_id", load_id_o, id);
        check("complete_drop", data_complete_o, 0);
        tick();
        data_prepare_i = 1'b0;
        sample();
        check("load_req_once", load_req_o, 0);
        check("ready_before_done", data_ready_o, 0);
        repeat (3) tick();
        load_done_i = 1'b1;
        sample();
        check("ready_after_done", data_ready_o, 1);
        tick();
        load_done_i = 1'b0;
    endtask

    task automatic start_scan(input int w, input int h, input int t);
        int n;
        if (data_start_i) begin
            // Start level carried over from the previous job must not retrigger.
            repeat (3) begin
                sample();
                check("no_retrigger_valid", tile_valid_o, 0);
                check("no_retrigger_ready", data_ready_o, 1);
            end
            tick();
            data_start_i = 1'b0;
        end
        push_model(w, h, t, n);
        tick();
        data_start_i = 1'b1;
        sample();
        check("start_valid", tile_valid_o, (n > 0) ? 1 : 0);
        check("start_complete", data_complete_o, (n == 0) ? 1 : 0);
        check("start_ready_drop", data_ready_o, 0);
    endtask

    task automatic finish_scan();
        int k;
        k = 0;
        while (!data_complete_o && k < 20000) begin
            sample();
            k++;
        end
        check("complete_seen", data_complete_o, 1);
        check("queue_drained", exp_q.size(), 0);
        check("valid_after_done", tile_valid_o, 0);
        repeat (3) sample();
        check("complete_held", data_complete_o, 1);
    endtask

    task automatic run_job(input int w, input int h, input int t, input int id);
        configure(w, h, t);
        load(id);
        start_scan(w, h, t);
        finish_scan();
    endtask

    // PE-array side: mostly ready, with occasional 3-cycle stalls.
    initial begin
        forever begin
            tick();
            if (stall_cnt > 0) begin
                tile_ready_i = 1'b0;
                stall_cnt--;
            end else if ($urandom_range(0, 5) == 0) begin
                tile_ready_i = 1'b0;
                stall_cnt = 2;
            end else begin
                tile_ready_i = 1'b1;
            end
        end
    end

    // Monitor: every accepted tile must match the head of the expected queue,
    // and a stalled tile must not change before it is accepted.
    initial begin
        int got, held, e;
        bit hold_pending;
        hold_pending = 0;
        held = 0;
        forever begin
            @(negedge clk);
            if (!reset && tile_valid_o) begin
                got = int'({tile_x_o, tile_y_o, tile_last_o, tile_partial_o});
                if (hold_pending) check("tile_hold", got, held);
                if (tile_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_tile", got, 32'hffff_ffff);
                    end else begin
                        e = exp_q.pop_front();
                        check("tile", got, e);
                    end
                    hold_pending = 0;
                end else begin
                    hold_pending = 1;
                    held = got;
                end
            end else begin
                hold_pending = 0;
            end
        end
    end

    initial begin
        repeat (2) tick();
        sample();
        check_idle_outputs("rst");
        tick();
        reset = 1'b0;
        sample();
        check_idle_outputs("post_rst");

        run_job(6, 6, 0, 3);
        run_job(10, 7, 1, 9);
        run_job(2, 6, 0, 4);

        // Reset in the middle of a scan.
        configure(20, 20, 0);
        load(5);
        start_scan(20, 20, 0);
        repeat (6) sample();
        tick();
        reset = 1'b1;
        sample();
        check_idle_outputs("mid_rst");
        tick();
        reset = 1'b0;
        exp_q.delete();

        run_job(6, 6, 0, 12);
        for (int r = 0; r < 8; r++) begin
            run_job($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 1),
                    $urandom_range(0, 15));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
